// File: rtl/rtl_settings_pkg.sv
// Shared Avalon-MM bus settings used by mem_checker and its memory target.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package rtl_settings_pkg;

  localparam int AMM_ADDR_W  = 32;
  localparam int AMM_DATA_W  = 32;
  localparam int AMM_BURST_W = 8;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4 (maximal length, 255 states)
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/amm_rd_delay_line.sv
// Valid+data shift register that lines read beats up with the configured read latency.
// Latency: DEPTH cycles (DEPTH=0 is a pass-through).
// Backpressure: none; beats always advance, each stage holds its last data when idle.
module amm_rd_delay_line #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_vld = in_vld;
      assign out_dat = in_dat;
    end else begin : g_shift
      logic [DEPTH-1:0]  vld_q;
      logic [DATA_W-1:0] dat_q [DEPTH];

      // Shift beats one stage per cycle; data only moves with a valid beat so the tail holds
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= in_vld;
          if (in_vld) dat_q[0] <= in_dat;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_vld = vld_q[DEPTH-1];
      assign out_dat = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/amm_burst_mem_slave.sv
// Avalon-MM burst slave: on-chip RAM target for mem_checker with random stalls; ERR_INJECT_EN flips one bit on reads of one word.
// Latency: read beat issued in cycle N returns in cycle N+RD_LATENCY; beats back to back, in order.
// Backpressure: registered waitrequest_o, held high for a whole read burst and pseudo-randomly otherwise.
module amm_burst_mem_slave
  import rtl_settings_pkg::*;
#(
  parameter int         ADDR_W      = AMM_ADDR_W,
  parameter int         DATA_W      = AMM_DATA_W,
  parameter int         BURST_W     = AMM_BURST_W,
  parameter int         RAM_ADDR_W  = 10,
  parameter int         RD_LATENCY  = 4,
  parameter int         WAIT_THRESH = 0,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
`ifdef ERR_INJECT_EN
  ,
  parameter int         ERR_ADDR    = 0,
  parameter int         ERR_BIT     = 0
`endif
) (
  input  logic                clk_mem_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [DATA_W-1:0]   writedata_i,
  input  logic [DATA_W/8-1:0] byteenable_i,
  input  logic [BURST_W-1:0]  burstcount_i,
  output logic                waitrequest_o,
  output logic                readdatavalid_o,
  output logic [DATA_W-1:0]   readdata_o
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                state, state_nxt;
  logic [BURST_W-1:0]    bc_q, bc_nxt, cnt_q, cnt_nxt;
  logic [RAM_ADDR_W-1:0] base_q, base_nxt;
  logic [7:0]            lfsr_q;

  logic                  accept;
  logic [BURST_W-1:0]    bc_in;
  logic [RAM_ADDR_W-1:0] addr_in, burst_addr;
  logic                  wr_en, rd_issue;
  logic [RAM_ADDR_W-1:0] wr_addr, rd_addr;

  logic [DATA_W-1:0]     mem [2**RAM_ADDR_W];
  logic                  rd_vld_q;
  logic [DATA_W-1:0]     rd_dat_q;
  logic [DATA_W-1:0]     err_mask;

  // Upper address bits alias onto the RAM; they are intentionally unused
  logic unused_addr_hi;
  assign unused_addr_hi = ^address_i[ADDR_W-1:RAM_ADDR_W];

  assign accept     = (read_i | write_i) & ~waitrequest_o;
  assign bc_in      = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;
  assign addr_in    = address_i[RAM_ADDR_W-1:0];
  assign burst_addr = base_q + RAM_ADDR_W'(cnt_q);

  // Next state and per-cycle RAM commands; the first beat of a burst is served in the accept cycle
  always_comb begin
    state_nxt = state;
    bc_nxt    = bc_q;
    cnt_nxt   = cnt_q;
    base_nxt  = base_q;
    wr_en     = 1'b0;
    wr_addr   = burst_addr;
    rd_issue  = 1'b0;
    rd_addr   = burst_addr;
    unique case (state)
      IDLE: begin
        if (accept) begin
          base_nxt = addr_in;
          bc_nxt   = bc_in;
          cnt_nxt  = BURST_W'(1);
          if (write_i) begin
            // Write wins if a misbehaving master raises both strobes
            wr_en   = 1'b1;
            wr_addr = addr_in;
            if (bc_in != BURST_W'(1)) state_nxt = WR_BURST;
          end else begin
            rd_issue = 1'b1;
            rd_addr  = addr_in;
            if (bc_in != BURST_W'(1)) state_nxt = RD_BURST;
          end
        end
      end
      WR_BURST: begin
        if (accept && write_i) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt_q + BURST_W'(1);
          if (cnt_q == bc_q - BURST_W'(1)) state_nxt = IDLE;
        end
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        cnt_nxt  = cnt_q + BURST_W'(1);
        if (cnt_q == bc_q - BURST_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst state, stall LFSR and the registered waitrequest
  always_ff @(posedge clk_mem_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bc_q          <= '0;
      cnt_q         <= '0;
      base_q        <= '0;
      lfsr_q        <= LFSR_SEED;
      waitrequest_o <= 1'b1;
    end else begin
      state         <= state_nxt;
      bc_q          <= bc_nxt;
      cnt_q         <= cnt_nxt;
      base_q        <= base_nxt;
      lfsr_q        <= lfsr8_next(lfsr_q);
      waitrequest_o <= (state_nxt == RD_BURST) | (int'(lfsr_q) < WAIT_THRESH);
    end
  end

  // Byte-masked RAM write; contents survive reset
  always_ff @(posedge clk_mem_i) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (byteenable_i[b]) mem[wr_addr][b*8 +: 8] <= writedata_i[b*8 +: 8];
      end
    end
  end

`ifdef ERR_INJECT_EN
  assign err_mask = (rd_addr == RAM_ADDR_W'(ERR_ADDR)) ? (DATA_W'(1) << ERR_BIT) : '0;
`else
  assign err_mask = '0;
`endif

  // One-cycle RAM read stage; data register holds between beats
  always_ff @(posedge clk_mem_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) rd_dat_q <= mem[rd_addr] ^ err_mask;
    end
  end

  amm_rd_delay_line #(
    .DEPTH  (RD_LATENCY - 1),
    .DATA_W (DATA_W)
  ) u_rd_delay (
    .clk     (clk_mem_i),
    .rst     (rst_i),
    .in_vld  (rd_vld_q),
    .in_dat  (rd_dat_q),
    .out_vld (readdatavalid_o),
    .out_dat (readdata_o)
  );

endmodule

// File: tb/tb_amm_burst_mem_slave.sv
// Directed and scoreboarded bench for amm_burst_mem_slave (DATA_W=32, RAM_ADDR_W=10, RD_LATENCY=4, WAIT_THRESH=128).
// Latency: reads expect first beat RD_LATENCY cycles after the accept cycle.
// Backpressure: master holds each beat until waitrequest_o is low at the sampling edge.
`timescale 1ns/1ps
module tb_amm_burst_mem_slave;

  localparam int RAM_ADDR_W = 10;
  localparam int DEPTH      = 1 << RAM_ADDR_W;
  localparam int RD_LATENCY = 4;

  logic        clk_mem_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] address_i = '0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] writedata_i = '0;
  logic [3:0]  byteenable_i = '0;
  logic [7:0]  burstcount_i = '0;
  logic        waitrequest_o;
  logic        readdatavalid_o;
  logic [31:0] readdata_o;

  amm_burst_mem_slave #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .BURST_W     (8),
    .RAM_ADDR_W  (RAM_ADDR_W),
    .RD_LATENCY  (RD_LATENCY),
    .WAIT_THRESH (128),
    .LFSR_SEED   (8'hA5)
`ifdef ERR_INJECT_EN
    ,
    .ERR_ADDR    (3),
    .ERR_BIT     (0)
`endif
  ) dut (
    .clk_mem_i       (clk_mem_i),
    .rst_i           (rst_i),
    .address_i       (address_i),
    .read_i          (read_i),
    .write_i         (write_i),
    .writedata_i     (writedata_i),
    .byteenable_i    (byteenable_i),
    .burstcount_i    (burstcount_i),
    .waitrequest_o   (waitrequest_o),
    .readdatavalid_o (readdatavalid_o),
    .readdata_o      (readdata_o)
  );

  always #5 clk_mem_i = ~clk_mem_i;

  int cyc = 0;
  always @(posedge clk_mem_i) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  int          beat_cnt = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] wdat_q [$];
  logic [3:0]  wbe_q [$];
  logic [31:0] rd_q [$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int idx);
    logic [31:0] v;
    v = mdl[idx];
`ifdef ERR_INJECT_EN
    if (idx == 3) v[0] = ~v[0];
`endif
    return v;
  endfunction

  task automatic amm_write(input logic [31:0] addr, input int bc);
    int n;
    int guard;
    int idx;
    n = (bc == 0) ? 1 : bc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_mem_i);
      address_i    = addr;
      burstcount_i = 8'(bc);
      write_i      = 1'b1;
      writedata_i  = wdat_q[i];
      byteenable_i = wbe_q[i];
      guard = 0;
      while (waitrequest_o && guard < 100) begin
        stall_cnt++;
        @(negedge clk_mem_i);
        guard++;
      end
      if (waitrequest_o) chk_eq("wr_wait_timeout", 32'(waitrequest_o), 32'd0);
      beat_cnt++;
      idx = (int'(addr[RAM_ADDR_W-1:0]) + i) % DEPTH;
      for (int b = 0; b < 4; b++)
        if (wbe_q[i][b]) mdl[idx][b*8 +: 8] = wdat_q[i][b*8 +: 8];
    end
    @(negedge clk_mem_i);
    write_i = 1'b0;
  endtask

  task automatic amm_read(input logic [31:0] addr, input int bc);
    int n;
    int guard;
    int acc;
    int first;
    int last;
    int got;
    n = (bc == 0) ? 1 : bc;
    rd_q.delete();
    @(negedge clk_mem_i);
    address_i    = addr;
    burstcount_i = 8'(bc);
    read_i       = 1'b1;
    guard = 0;
    while (waitrequest_o && guard < 100) begin
      @(negedge clk_mem_i);
      guard++;
    end
    if (waitrequest_o) chk_eq("rd_wait_timeout", 32'(waitrequest_o), 32'd0);
    acc = cyc;
    first = -1;
    last = -1;
    got = 0;
    guard = 0;
    @(negedge clk_mem_i);
    read_i = 1'b0;
    while (got < n && guard < n + RD_LATENCY + 20) begin
      if (readdatavalid_o) begin
        rd_q.push_back(readdata_o);
        if (got == 0) first = cyc;
        last = cyc;
        got++;
      end
      @(negedge clk_mem_i);
      guard++;
    end
    chk_eq("rd_beats", 32'(got), 32'(n));
    chk_eq("rd_latency", 32'(first - acc), 32'(RD_LATENCY));
    chk_eq("rd_back_to_back", 32'(last - first), 32'(n - 1));
  endtask

  task automatic set_beats(input logic [31:0] d0, input int n, input logic [3:0] be);
    wdat_q.delete();
    wbe_q.delete();
    for (int i = 0; i < n; i++) begin
      wdat_q.push_back(d0 + 32'(i));
      wbe_q.push_back(be);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          viol;
    int          a;
    int          bcr;
    logic [31:0] up;
    logic [31:0] addr;
    int          rate;

    // Reset state and waitrequest release timing
    repeat (3) @(negedge clk_mem_i);
    chk_eq("rst_waitrequest", 32'(waitrequest_o), 32'd1);
    chk_eq("rst_readdatavalid", 32'(readdatavalid_o), 32'd0);
    chk_eq("rst_readdata", readdata_o, 32'h0);
    rst_i = 1'b0;
    #1 chk_eq("wait_at_release", 32'(waitrequest_o), 32'd1);
    @(negedge clk_mem_i);
    chk_eq("wait_after_release", 32'(waitrequest_o), 32'd0);

    // Test 1: 4-beat write then 4-beat read at 0x10
    set_beats(32'd1, 4, 4'hF);
    amm_write(32'h10, 4);
    amm_read(32'h10, 4);
    for (int i = 0; i < 4; i++) chk_eq("t1_data", rd_q[i], 32'(i + 1));

    // Test 2: byte-enable merge on word 5
    set_beats(32'hFFFF_FFFF, 1, 4'hF);
    amm_write(32'd5, 1);
    set_beats(32'h0, 1, 4'b0010);
    amm_write(32'd5, 1);
    amm_read(32'd5, 1);
    chk_eq("t2_be_merge", rd_q[0], 32'hFFFF_00FF);

    // Test 3: burst wrapping past the top of the RAM
    set_beats(32'hA1, 3, 4'hF);
    amm_write(32'd1023, 3);
    amm_read(32'd0, 2);
    chk_eq("t3_wrap_beat1", rd_q[0], 32'hA2);
    chk_eq("t3_wrap_beat2", rd_q[1], 32'hA3);
    amm_read(32'd1023, 1);
    chk_eq("t3_wrap_beat0", rd_q[0], 32'hA1);

    // burstcount 0 behaves as a single beat
    set_beats(32'h0BAD_C0DE, 1, 4'hF);
    amm_write(32'd9, 0);
    amm_read(32'd9, 0);
    chk_eq("bc0_data", rd_q[0], 32'h0BAD_C0DE);

    // Test 5: reset during beat 2 of an 8-beat read
    set_beats(32'h5000_0000, 8, 4'hF);
    amm_write(32'h40, 8);
    @(negedge clk_mem_i);
    address_i = 32'h40;
    burstcount_i = 8'd8;
    read_i = 1'b1;
    viol = 0;
    while (waitrequest_o && viol < 100) begin
      @(negedge clk_mem_i);
      viol++;
    end
    @(negedge clk_mem_i);
    read_i = 1'b0;
    @(negedge clk_mem_i);
    rst_i = 1'b1;
    #1 chk_eq("t5_wait_in_reset", 32'(waitrequest_o), 32'd1);
    viol = 0;
    repeat (2) begin
      @(negedge clk_mem_i);
      if (readdatavalid_o || !waitrequest_o) viol++;
    end
    rst_i = 1'b0;
    repeat (20) begin
      @(negedge clk_mem_i);
      if (readdatavalid_o) viol++;
    end
    chk_eq("t5_no_stale_beats", 32'(viol), 32'd0);
    amm_read(32'h40, 8);
    for (int i = 0; i < 8; i++) chk_eq("t5_reread", rd_q[i], 32'h5000_0000 + 32'(i));

`ifdef ERR_INJECT_EN
    // Test 6: bit 0 of word 3 inverted on read only
    set_beats(32'h0, 3, 4'hF);
    for (int i = 0; i < 3; i++) wdat_q[i] = 32'h0;
    amm_write(32'd2, 3);
    amm_read(32'd2, 3);
    chk_eq("t6_word2", rd_q[0], 32'h0);
    chk_eq("t6_word3", rd_q[1], 32'h1);
    chk_eq("t6_word4", rd_q[2], 32'h0);
    amm_read(32'd3, 1);
    chk_eq("t6_reread3", rd_q[0], 32'h1);
`endif

    // Test 4: random bursts against the model, aliased upper address bits
    wdat_q.delete();
    wbe_q.delete();
    for (int i = 0; i < 80; i++) begin
      wdat_q.push_back($urandom);
      wbe_q.push_back(4'hF);
    end
    amm_write(32'h0, 80);
    stall_cnt = 0;
    beat_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      a    = $urandom_range(0, 63);
      bcr  = $urandom_range(1, 8);
      up   = $urandom;
      addr = {up[31:RAM_ADDR_W], 10'(a)};
      if ($urandom_range(0, 1) == 1) begin
        wdat_q.delete();
        wbe_q.delete();
        for (int i = 0; i < bcr; i++) begin
          wdat_q.push_back($urandom);
          wbe_q.push_back(4'($urandom));
        end
        amm_write(addr, bcr);
      end else begin
        amm_read(addr, bcr);
        for (int i = 0; i < rd_q.size(); i++)
          chk_eq("t4_rand_data", rd_q[i], exp_rd((a + i) % DEPTH));
      end
    end
    rate = (stall_cnt * 100) / (stall_cnt + beat_cnt + 1);
    $display("stall rate %0d%% (%0d stalls, %0d beats)", rate, stall_cnt, beat_cnt);
    chk_eq("t4_stall_rate_40_60", 32'(rate >= 40 && rate <= 60), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
